btn_cond: RTL and testbench

Button conditioning stage between the raw board push-buttons and the Mastermind game logic. Each asynchronous button input is synchronised to `clk` and debounced. Each button then produces a clean level plus a single-cycle press pulse. In the top level, the press pulses drive the `setans_btn` and `guess_btn` inputs, so the game FSM sees exactly one event per physical press.

---
 rtl/mmind_pkg.sv | 14 +
 rtl/btn_debounce1.sv | 75 +++++++
 rtl/btn_cond.sv | 34 +++
 tb/tb_btn_cond.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmind_pkg.sv
// Shared constants for the Mastermind button path: debounce lengths and button indices.
package mmind_pkg;

  localparam int MMIND_DB_CYCLES     = 250000;  // 2.5 ms at 100 MHz
  localparam int MMIND_DB_CYCLES_SIM = 4;
  localparam int MMIND_BTN_SETANS    = 0;
  localparam int MMIND_BTN_GUESS     = 1;

  // Counter width for a debounce length, never narrower than one bit.
  function automatic int db_cnt_width(input int db_cycles);
    return (db_cycles > 1) ? $clog2(db_cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce1.sv
// One button channel: two-flop synchroniser, debounce counter, stable level and edge pulses.
// Optional release pulse built when BTN_COND_RELEASE_EN is defined.
module btn_debounce1
  import mmind_pkg::*;
#(
  parameter int DB_CYCLES = MMIND_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
`ifdef BTN_COND_RELEASE_EN
  output logic release_pulse,
`endif
  output logic press
);

  localparam int CW = db_cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          stable_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          flip;

  // Debounce decision: a bounce back to the current state restarts the count.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = {CW{1'b0}};
    flip       = 1'b0;
    if (s2 == stable) begin
      cnt_nxt = {CW{1'b0}};
    end else if (cnt == CNT_MAX) begin
      stable_nxt = s2;
      cnt_nxt    = {CW{1'b0}};
      flip       = 1'b1;
    end else begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // Synchroniser, debounce state and edge pulses, aligned with the level change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= {CW{1'b0}};
      press  <= 1'b0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      stable <= stable_nxt;
      cnt    <= cnt_nxt;
      press  <= flip & s2;
    end
  end

`ifdef BTN_COND_RELEASE_EN
  // Release pulse on a debounced 1->0 transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      release_pulse <= 1'b0;
    end else begin
      release_pulse <= flip & ~s2;
    end
  end
`endif

  assign level = stable;

endmodule

// File: rtl/btn_cond.sv
// Button conditioning: NBTN independent debounce channels producing level and press pulses.
// btn_release exists only when BTN_COND_RELEASE_EN is defined.
module btn_cond
  import mmind_pkg::*;
#(
  parameter int NBTN      = 2,
  parameter int DB_CYCLES = MMIND_DB_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
`ifdef BTN_COND_RELEASE_EN
  output logic [NBTN-1:0] btn_release,
`endif
  output logic [NBTN-1:0] btn_press
);

  for (genvar i = 0; i < NBTN; i++) begin : gen_ch
    btn_debounce1 #(
      .DB_CYCLES(DB_CYCLES)
    ) u_deb (
      .clk          (clk),
      .reset        (reset),
      .raw          (btn_raw[i]),
      .level        (btn_level[i]),
`ifdef BTN_COND_RELEASE_EN
      .release_pulse(btn_release[i]),
`endif
      .press        (btn_press[i])
    );
  end

endmodule

// File: tb/tb_btn_cond.sv
// Scoreboard bench for btn_cond with DB_CYCLES=4, NBTN=2; release checks when BTN_COND_RELEASE_EN is defined.
module tb_btn_cond;
  import mmind_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] rel_obs;
`ifdef BTN_COND_RELEASE_EN
  logic [1:0] btn_release;
  assign rel_obs = btn_release;
`else
  assign rel_obs = 2'b00;
`endif

  btn_cond #(.NBTN(2), .DB_CYCLES(MMIND_DB_CYCLES_SIM)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
`ifdef BTN_COND_RELEASE_EN
    .btn_release(btn_release),
`endif
    .btn_press(btn_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] press;
    logic [1:0] level;
    logic [1:0] rel;
    logic [1:0] cnt0;
    logic [1:0] cnt1;
    bit         chk_cnt;
  } rec_t;

  logic [1:0] stim[$];
  rec_t       expq[$];
  rec_t       obsq[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic rec_t mk(input logic [1:0] p, input logic [1:0] l, input logic [1:0] r,
                              input logic [1:0] c0, input logic [1:0] c1, input bit cc);
    rec_t e;
    e.press = p; e.level = l; e.rel = r; e.cnt0 = c0; e.cnt1 = c1; e.chk_cnt = cc;
    return e;
  endfunction

  task automatic sched(input logic [1:0] raw, input rec_t e);
    stim.push_back(raw);
    expq.push_back(e);
  endtask

  // Drive queued stimulus one cycle at a time and record outputs 1 ns after each edge.
  task automatic play();
    rec_t o;
    while (stim.size() > 0) begin
      btn_raw = stim.pop_front();
      @(posedge clk);
      #1;
      o.press = btn_press; o.level = btn_level; o.rel = rel_obs;
      o.cnt0 = dut.gen_ch[0].u_deb.cnt; o.cnt1 = dut.gen_ch[1].u_deb.cnt; o.chk_cnt = 1'b0;
      obsq.push_back(o);
    end
  endtask

  // Release sequence for channels that are currently high: level drops and release pulses at edge 6.
  task automatic sched_release(input logic [1:0] held, input logic [1:0] keep);
    for (int k = 1; k <= 8; k++)
      sched(keep, mk(2'b00, (k >= 6) ? keep : (held | keep), (k == 6) ? held : 2'b00, 2'b00, 2'b00, 1'b0));
  endtask

  task automatic test_reset();
    rec_t e, o;
    for (int k = 1; k <= 7; k++)
      sched(2'b11, mk((k == 6) ? 2'b11 : 2'b00, (k >= 6) ? 2'b11 : 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    for (int k = 1; k <= 3; k++)
      sched(2'b00, mk(2'b00, 2'b11, 2'b00, (k == 3) ? 2'b01 : 2'b00, (k == 3) ? 2'b01 : 2'b00, 1'b1));
    play();
    for (int k = 1; k <= 10; k++) begin
      e = expq.pop_front(); o = obsq.pop_front();
      n_checks++;
      if (o.press !== e.press || o.level !== e.level) begin
        n_fail++;
        $display("FAIL reset_pre cyc %0d press=%b level=%b required press=%b level=%b", k, o.press, o.level, e.press, e.level);
      end
      if (e.chk_cnt) begin
        n_checks++;
        if (o.cnt0 !== e.cnt0 || o.cnt1 !== e.cnt1) begin
          n_fail++;
          $display("FAIL reset_pre_cnt cyc %0d cnt=%0d/%0d required %0d/%0d", k, o.cnt0, o.cnt1, e.cnt0, e.cnt1);
        end
      end
    end
    // Assert reset between edges with buttons pressed: outputs must clear without a clock edge.
    btn_raw = 2'b11;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (btn_level !== 2'b00 || btn_press !== 2'b00 || rel_obs !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_async level=%b press=%b rel=%b required 00", btn_level, btn_press, rel_obs);
    end
    n_checks++;
    if (dut.gen_ch[0].u_deb.cnt !== 2'd0 || dut.gen_ch[1].u_deb.cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_cnt cnt=%0d/%0d required 0/0", dut.gen_ch[0].u_deb.cnt, dut.gen_ch[1].u_deb.cnt);
    end
    btn_raw = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    rec_t e, o;
    for (int k = 1; k <= 56; k++)
      sched(2'b01, mk((k == 6) ? 2'b01 : 2'b00, (k >= 6) ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    play();
    for (int k = 1; k <= 56; k++) begin
      e = expq.pop_front(); o = obsq.pop_front();
      n_checks++;
      if (o.press !== e.press || o.level !== e.level) begin
        n_fail++;
        $display("FAIL clean_press cyc %0d press=%b level=%b required press=%b level=%b", k, o.press, o.level, e.press, e.level);
      end
    end
  endtask

  task automatic test_release();
    rec_t e, o;
    sched_release(2'b01, 2'b00);
    play();
    for (int k = 1; k <= 8; k++) begin
      e = expq.pop_front(); o = obsq.pop_front();
      n_checks++;
      if (o.press !== e.press || o.level !== e.level) begin
        n_fail++;
        $display("FAIL release cyc %0d press=%b level=%b required press=%b level=%b", k, o.press, o.level, e.press, e.level);
      end
`ifdef BTN_COND_RELEASE_EN
      n_checks++;
      if (o.rel !== e.rel) begin
        n_fail++;
        $display("FAIL release_pulse cyc %0d rel=%b required %b", k, o.rel, e.rel);
      end
`endif
    end
  endtask

  task automatic test_bounce();
    rec_t e, o;
    logic [1:0] pat[8];
    pat = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
    for (int k = 1; k <= 8; k++)
      sched(pat[k-1], mk(2'b00, 2'b00, 2'b00, 2'b00, (k == 5 || k == 9) ? 2'd3 : 2'd0,
                         (k == 5 || k == 6 || k == 10)));
    for (int k = 9; k <= 18; k++)
      sched(2'b10, mk((k == 14) ? 2'b10 : 2'b00, (k >= 14) ? 2'b10 : 2'b00, 2'b00, 2'b00, 2'b00, k == 10));
    sched_release(2'b10, 2'b00);
    play();
    for (int k = 1; k <= 26; k++) begin
      e = expq.pop_front(); o = obsq.pop_front();
      n_checks++;
      if (o.press !== e.press || o.level !== e.level) begin
        n_fail++;
        $display("FAIL bounce cyc %0d press=%b level=%b required press=%b level=%b", k, o.press, o.level, e.press, e.level);
      end
      if (e.chk_cnt) begin
        n_checks++;
        if (o.cnt1 !== e.cnt1) begin
          n_fail++;
          $display("FAIL bounce_cnt cyc %0d cnt1=%0d required %0d", k, o.cnt1, e.cnt1);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    rec_t e, o;
    for (int k = 1; k <= 10; k++)
      sched(2'b11, mk((k == 6) ? 2'b11 : 2'b00, (k >= 6) ? 2'b11 : 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    sched_release(2'b11, 2'b00);
    play();
    for (int k = 1; k <= 18; k++) begin
      e = expq.pop_front(); o = obsq.pop_front();
      n_checks++;
      if (o.press !== e.press || o.level !== e.level) begin
        n_fail++;
        $display("FAIL simultaneous cyc %0d press=%b level=%b required press=%b level=%b", k, o.press, o.level, e.press, e.level);
      end
`ifdef BTN_COND_RELEASE_EN
      n_checks++;
      if (o.rel !== e.rel) begin
        n_fail++;
        $display("FAIL simultaneous_rel cyc %0d rel=%b required %b", k, o.rel, e.rel);
      end
`endif
    end
  endtask

  task automatic test_reset_midcount();
    rec_t e, o;
    for (int k = 1; k <= 3; k++)
      sched(2'b01, mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    play();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 1; k <= 8; k++)
      sched(2'b01, mk((k == 6) ? 2'b01 : 2'b00, (k >= 6) ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    sched_release(2'b01, 2'b00);
    play();
    for (int k = 1; k <= 19; k++) begin
      e = expq.pop_front(); o = obsq.pop_front();
      n_checks++;
      if (o.press !== e.press || o.level !== e.level) begin
        n_fail++;
        $display("FAIL reset_midcount step %0d press=%b level=%b required press=%b level=%b", k, o.press, o.level, e.press, e.level);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    repeat (3) @(posedge clk);
    #1;
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
